// File: rtl/es_pkg.sv
// es_pkg: shared types and constants for the I/O unit (ES_DEBOUNCE_EN selects the button filter)
package es_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        ARMADO,
        ACK,
        ESPERA_SOLTA
    } estado_es_t;

    localparam int ES_DATA_WIDTH_DEF = 32;
    localparam int ES_CONT_WIDTH     = 8;

endpackage

// File: rtl/filtro_botao.sv
// filtro_botao: two-flop synchronizer plus optional debounce counter (enabled by ES_DEBOUNCE_EN)
module filtro_botao
`ifdef ES_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 50000
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic saida
);

    logic [1:0] sinc_q, sinc_d;

    // shift the raw button into the synchronizer chain
    always_comb begin
        sinc_d = {sinc_q[0], entrada};
    end

    // synchronizer flops
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc_q <= '0;
        end else begin
            sinc_q <= sinc_d;
        end
    end

`ifdef ES_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cont_q, cont_d;
    logic          filt_q, filt_d;

    // count consecutive disagreement cycles; toggle on the DEBOUNCE_CYCLES-th, clear on any agreement
    always_comb begin
        cont_d = '0;
        filt_d = filt_q;
        if (sinc_q[1] != filt_q) begin
            if (cont_q == CW'(DEBOUNCE_CYCLES - 1)) filt_d = ~filt_q;
            else cont_d = cont_q + 1'b1;
        end
    end

    // debounce counter and filtered level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
            filt_q <= 1'b0;
        end else begin
            cont_q <= cont_d;
            filt_q <= filt_d;
        end
    end

    assign saida = filt_q;
`else
    assign saida = sinc_q[1];
`endif

endmodule

// File: rtl/unidade_entrada_saida.sv
// unidade_entrada_saida: button/switch input handshake and held display output (filter via ES_DEBOUNCE_EN)
module unidade_entrada_saida
    import es_pkg::*;
#(
    parameter int DATA_WIDTH      = ES_DATA_WIDTH_DEF,
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     botao_bruto,
    input  logic [SW_WIDTH-1:0]      chaves,
    input  logic                     halt_req,
    input  logic                     opt,
    input  logic [DATA_WIDTH-1:0]    dado_saida,
    output logic                     botao,
    output logic [DATA_WIDTH-1:0]    dado_entrada,
    output logic [DATA_WIDTH-1:0]    display,
    output logic                     display_valido,
    output logic [ES_CONT_WIDTH-1:0] contador_saida
);

    if (SW_WIDTH > DATA_WIDTH || DEBOUNCE_CYCLES < 1) begin : g_param_invalido
        $error("unidade_entrada_saida: invalid SW_WIDTH/DEBOUNCE_CYCLES");
    end

    estado_es_t                estado_q, estado_d;
    logic                      botao_filtrado;
    logic                      botao_filtrado_q, botao_filtrado_d;
    logic                      subida;
    logic                      botao_q, botao_d;
    logic [DATA_WIDTH-1:0]     dado_entrada_q, dado_entrada_d;
    logic [DATA_WIDTH-1:0]     display_q, display_d;
    logic                      display_valido_q, display_valido_d;
    logic [ES_CONT_WIDTH-1:0]  contador_q, contador_d;

    filtro_botao
`ifdef ES_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    )
`endif
    u_filtro (
        .clock   (clock),
        .reset   (reset),
        .entrada (botao_bruto),
        .saida   (botao_filtrado)
    );

    assign subida = botao_filtrado & ~botao_filtrado_q;

    // input handshake FSM; switches are captured on the accepting press, botao is a delayed state decode
    always_comb begin
        estado_d         = estado_q;
        botao_filtrado_d = botao_filtrado;
        botao_d          = (estado_q == ACK);
        dado_entrada_d   = dado_entrada_q;
        unique case (estado_q)
            OCIOSO:       estado_d = halt_req ? ARMADO : OCIOSO;
            ARMADO: begin
                if (subida) begin
                    estado_d       = ACK;
                    dado_entrada_d = DATA_WIDTH'(chaves);
                end else if (!halt_req) begin
                    estado_d = OCIOSO;
                end
            end
            ACK:          estado_d = ESPERA_SOLTA;
            ESPERA_SOLTA: estado_d = botao_filtrado ? ESPERA_SOLTA : OCIOSO;
            default:      estado_d = OCIOSO;
        endcase
    end

    // output path: every cycle with opt latches the value and bumps the wrapping counter
    always_comb begin
        display_d        = opt ? dado_saida : display_q;
        display_valido_d = display_valido_q | opt;
        contador_d       = contador_q + ES_CONT_WIDTH'(opt);
    end

    // state and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q         <= OCIOSO;
            botao_filtrado_q <= 1'b0;
            botao_q          <= 1'b0;
            dado_entrada_q   <= '0;
            display_q        <= '0;
            display_valido_q <= 1'b0;
            contador_q       <= '0;
        end else begin
            estado_q         <= estado_d;
            botao_filtrado_q <= botao_filtrado_d;
            botao_q          <= botao_d;
            dado_entrada_q   <= dado_entrada_d;
            display_q        <= display_d;
            display_valido_q <= display_valido_d;
            contador_q       <= contador_d;
        end
    end

    assign botao          = botao_q;
    assign dado_entrada   = dado_entrada_q;
    assign display        = display_q;
    assign display_valido = display_valido_q;
    assign contador_saida = contador_q;

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// tb_unidade_entrada_saida: randomized scoreboard bench for the I/O unit (honours ES_DEBOUNCE_EN)
module tb_unidade_entrada_saida;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int SW = 16;
`ifdef ES_DEBOUNCE_EN
    localparam int LAT = D + 4;
`else
    localparam int LAT = 4;
`endif

    logic          clock, reset, botao_bruto, halt_req, opt;
    logic [SW-1:0] chaves;
    logic [DW-1:0] dado_saida;
    logic          botao;
    logic [DW-1:0] dado_entrada, display;
    logic          display_valido;
    logic [7:0]    contador_saida;

    unidade_entrada_saida #(
        .DATA_WIDTH      (DW),
        .SW_WIDTH        (SW),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botao_bruto    (botao_bruto),
        .chaves         (chaves),
        .halt_req       (halt_req),
        .opt            (opt),
        .dado_saida     (dado_saida),
        .botao          (botao),
        .dado_entrada   (dado_entrada),
        .display        (display),
        .display_valido (display_valido),
        .contador_saida (contador_saida)
    );

    typedef struct { int ciclo; logic [DW-1:0] dado; } in_exp_t;
    typedef struct { logic [DW-1:0] disp; logic [7:0] cnt; } out_exp_t;

    in_exp_t  in_q[$];
    out_exp_t out_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       cyc = 0;
    logic     opt_at_edge = 1'b0;
    logic     botao_prev = 1'b0;
    logic [7:0] cnt_m = 8'd0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        opt_at_edge <= opt;
    end

    task automatic chk(input string nome, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    task automatic mon_botao();
        in_exp_t e;
        if (in_q.size() == 0) begin
            chk("botao_inesperado", 64'(botao), 64'd0);
        end else begin
            e = in_q.pop_front();
            chk("ciclo_botao", 64'(cyc), 64'(e.ciclo));
            chk("dado_entrada", 64'(dado_entrada), 64'(e.dado));
        end
        chk("largura_botao", 64'(botao_prev), 64'd0);
    endtask

    task automatic mon_out();
        out_exp_t e;
        if (out_q.size() == 0) begin
            chk("out_inesperado", 64'(opt_at_edge), 64'd0);
        end else begin
            e = out_q.pop_front();
            chk("display", 64'(display), 64'(e.disp));
            chk("contador_saida", 64'(contador_saida), 64'(e.cnt));
            chk("display_valido", 64'(display_valido), 64'd1);
        end
    endtask

    // monitor: pops the scoreboards whenever the DUT presents a pulse or an out update
    always @(negedge clock) begin
        if (!reset) begin
            if (botao) mon_botao();
            if (opt_at_edge) mon_out();
        end
        botao_prev <= botao;
    end

    task automatic pulse_opt(input logic [DW-1:0] v);
        opt        = 1'b1;
        dado_saida = v;
        cnt_m      = cnt_m + 8'd1;
        out_q.push_back('{v, cnt_m});
        @(negedge clock);
        opt = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_botao"}, 64'(botao), 64'd0);
        chk({tag, "_dado_entrada"}, 64'(dado_entrada), 64'd0);
        chk({tag, "_display"}, 64'(display), 64'd0);
        chk({tag, "_display_valido"}, 64'(display_valido), 64'd0);
        chk({tag, "_contador"}, 64'(contador_saida), 64'd0);
    endtask

    task automatic pressiona(input bit com_opt, input bit reset_ack);
        int t;
        botao_bruto = 1'b1;
        t = cyc + LAT;
        in_q.push_back('{t, DW'(chaves)});
        while (cyc < t - 1) @(negedge clock);
        if (com_opt) pulse_opt($urandom);
        else @(negedge clock);
        if (reset_ack) begin
            #1 reset = 1'b1;
            #1 chk_zero("reset_ack");
            cnt_m = 8'd0;
            halt_req = 1'b0;
            @(negedge clock);
            reset = 1'b0;
        end
        halt_req    = 1'b0;
        botao_bruto = 1'b0;
        chaves      = SW'($urandom);
        repeat (D + 6) @(negedge clock);
    endtask

    task automatic do_in(input logic [SW-1:0] sw, input bit com_opt, input bit reset_ack);
        halt_req = 1'b1;
        chaves   = sw;
        repeat (2) @(negedge clock);
        pressiona(com_opt, reset_ack);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        botao_bruto = 1'b0;
        halt_req    = 1'b0;
        opt         = 1'b0;
        chaves      = '0;
        dado_saida  = '0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        pulse_opt(32'hDEADBEEF);
        for (int i = 0; i < 256; i++) begin
            pulse_opt($urandom);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end
        repeat (2) @(negedge clock);

        do_in(16'h00A5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) do_in(SW'($urandom), 1'($urandom_range(0, 1)), 1'b0);

`ifdef ES_DEBOUNCE_EN
        halt_req = 1'b1;
        chaves   = SW'($urandom);
        repeat (2) @(negedge clock);
        for (int n = 0; n < 20; ) begin
            int h, l;
            h = $urandom_range(1, D - 1);
            l = $urandom_range(1, 3);
            botao_bruto = 1'b1;
            repeat (h) @(negedge clock);
            botao_bruto = 1'b0;
            repeat (l) @(negedge clock);
            n += h + l;
        end
        pressiona(1'b0, 1'b0);
`endif

        botao_bruto = 1'b1;
        repeat (D + 6) @(negedge clock);
        halt_req = 1'b1;
        chaves   = SW'($urandom);
        repeat (12) @(negedge clock);
        botao_bruto = 1'b0;
        repeat (D + 6) @(negedge clock);
        pressiona(1'b1, 1'b0);

        do_in(SW'($urandom), 1'b0, 1'b1);
        pulse_opt($urandom);
        do_in(SW'($urandom), 1'b1, 1'b0);

        repeat (5) @(negedge clock);
        chk("in_q_pendente", 64'(in_q.size()), 64'd0);
        chk("out_q_pendente", 64'(out_q.size()), 64'd0);
        chk("contador_final", 64'(contador_saida), 64'(cnt_m));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
